// File: rtl/vga_sync_monitor_pkg.sv
// Shared timing defaults, error causes, FSM encodings and counter helpers
// for the VGA sync monitor.
package vga_sync_monitor_pkg;

  // Default 640x480 timing in pixel ticks / lines.
  localparam int   H_TOTAL_DEF     = 800;
  localparam int   H_SYNC_DEF      = 96;
  localparam int   V_TOTAL_DEF     = 521;
  localparam int   V_SYNC_DEF      = 2;
  localparam logic SYNC_POL_DEF    = 1'b0;
  localparam int   LOCK_FRAMES_DEF = 2;

  // All measurement counters are 10 bits and saturate at all-ones.
  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  // First-error cause codes; a lower value has priority on a shared tick.
  typedef logic [2:0] err_code_t;
  localparam err_code_t ERR_NONE     = 3'd0;
  localparam err_code_t ERR_H_PERIOD = 3'd1;
  localparam err_code_t ERR_H_WIDTH  = 3'd2;
  localparam err_code_t ERR_V_LINES  = 3'd3;
  localparam err_code_t ERR_V_WIDTH  = 3'd4;
  localparam err_code_t ERR_TIMEOUT  = 3'd5;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_t;

  // Increment that sticks at CNT_MAX instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? CNT_MAX : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/vga_sync_monitor_if.sv
// Bundle of the sync signals under test, the error-clear strobe and the
// monitor's status outputs. Inputs are only looked at on clocks where
// pix_en is 1 (err_clr excepted, which acts on any clock); there is no
// valid/ready handshake, the monitor never back-pressures the source.
interface vga_sync_monitor_if;
  import vga_sync_monitor_pkg::*;

  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       err_clr;
  logic       locked;
  logic       err_sticky;
  err_code_t  err_code;
  logic [7:0] frame_cnt;
  cnt_t       line_cnt;
  cnt_t       h_period_meas;
  mon_state_t dbg_state;

  // Source side: the sync generator tap plus whoever reads the status.
  modport master (
    output pix_en, hsync, vsync, err_clr,
    input  locked, err_sticky, err_code, frame_cnt, line_cnt,
           h_period_meas, dbg_state
  );

  // Monitor side.
  modport slave (
    input  pix_en, hsync, vsync, err_clr,
    output locked, err_sticky, err_code, frame_cnt, line_cnt,
           h_period_meas, dbg_state
  );
endinterface

// File: rtl/vga_sync_monitor_sync_pulse_meas.sv
// Edge detector plus period and width counters for one sync pulse.
// Edge outputs are combinational and valid only on enabled clocks; the
// counters advance on those same clocks and so are seen one clock later.
module sync_pulse_meas
  import vga_sync_monitor_pkg::*;
#(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sig,
  output logic assert_edge,
  output logic deassert_edge,
  output cnt_t cnt,
  output cnt_t width
);

  logic prev_q;
  cnt_t cnt_q;
  cnt_t wid_q;
  logic active;
  logic prev_active;

  assign active        = (sig == POL);
  assign prev_active   = (prev_q == POL);
  assign assert_edge   = en & active & ~prev_active;
  assign deassert_edge = en & ~active & prev_active;
  assign cnt           = cnt_q;
  assign width         = wid_q;

  // Previous level, ticks since the last assert edge, ticks held active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= ~POL;
      cnt_q  <= '0;
      wid_q  <= '0;
    end else if (en) begin
      prev_q <= sig;
      if (assert_edge) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= sat_inc(cnt_q);
      end
      if (assert_edge) begin
        wid_q <= cnt_t'(1);
      end else if (active) begin
        wid_q <= sat_inc(wid_q);
      end
    end
  end

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side checker for a VGA sync stream: measures line period, hsync
// width, lines per frame and vsync width, locks after consecutive good
// frames and records the first error cause once locked.
module vga_sync_monitor
  import vga_sync_monitor_pkg::*;
#(
  parameter int   H_TOTAL     = H_TOTAL_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   V_TOTAL     = V_TOTAL_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter logic SYNC_POL    = SYNC_POL_DEF,
  parameter int   LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input logic               clk,
  input logic               rst,
  vga_sync_monitor_if.slave bus
);

  logic       h_as, h_de, v_as, v_de, v_en;
  cnt_t       h_cnt, h_wid, v_cnt, v_wid;
  cnt_t       h_per, v_lines;
  logic       mis_h_period, mis_h_width, mis_v_lines, mis_v_width;
  logic       mis_any, h_to, v_to, timeout;
  err_code_t  err_cause;

  mon_state_t state_q, state_d;
  logic [7:0] good_q, good_d;
  logic       frame_bad_q, frame_bad_d;
  logic       frame_inc, err_set;
  logic [7:0] frame_cnt_q;
  logic       err_sticky_q;
  err_code_t  err_code_q;
  cnt_t       h_period_q;

  // Horizontal path counts pixel ticks.
  sync_pulse_meas #(.POL(SYNC_POL)) u_h_meas (
    .clk           (clk),
    .rst           (rst),
    .en            (bus.pix_en),
    .sig           (bus.hsync),
    .assert_edge   (h_as),
    .deassert_edge (h_de),
    .cnt           (h_cnt),
    .width         (h_wid)
  );

  // Vertical path counts lines: it only advances on hsync assert edges,
  // so vsync is sampled at line starts and a coincident vsync edge makes
  // that new line line 0 while the hsync check closes the previous line.
  assign v_en = bus.pix_en & h_as;

  sync_pulse_meas #(.POL(SYNC_POL)) u_v_meas (
    .clk           (clk),
    .rst           (rst),
    .en            (v_en),
    .sig           (bus.vsync),
    .assert_edge   (v_as),
    .deassert_edge (v_de),
    .cnt           (v_cnt),
    .width         (v_wid)
  );

  assign h_per   = sat_inc(h_cnt);
  assign v_lines = sat_inc(v_cnt);

  assign mis_h_period = h_as & (h_per != cnt_t'(H_TOTAL));
  assign mis_h_width  = h_de & (h_wid != cnt_t'(H_SYNC));
  assign mis_v_lines  = v_as & (v_lines != cnt_t'(V_TOTAL));
  assign mis_v_width  = v_de & (v_wid != cnt_t'(V_SYNC));
  assign mis_any      = mis_h_period | mis_h_width | mis_v_lines | mis_v_width;

  // Timeout fires once, on the tick a counter climbs onto its saturation
  // value; a stuck vsync (1023 lines without an edge) is treated the same.
  assign h_to    = bus.pix_en & ~h_as & (h_cnt == CNT_MAX - cnt_t'(1));
  assign v_to    = v_en & ~v_as & (v_cnt == CNT_MAX - cnt_t'(1));
  assign timeout = h_to | v_to;

  // Lowest cause code wins when several checks fail on one tick.
  always_comb begin
    err_cause = ERR_NONE;
    if (mis_h_period)     err_cause = ERR_H_PERIOD;
    else if (mis_h_width) err_cause = ERR_H_WIDTH;
    else if (mis_v_lines) err_cause = ERR_V_LINES;
    else if (mis_v_width) err_cause = ERR_V_WIDTH;
    else if (timeout)     err_cause = ERR_TIMEOUT;
  end

  // Next state, good-frame counting and the error/frame strobes.
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_bad_d = frame_bad_q;
    frame_inc   = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        // The partial frame before the first vsync edge is never checked.
        if (v_as) begin
          state_d     = ST_MEASURE;
          good_d      = '0;
          frame_bad_d = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (timeout) begin
          state_d     = ST_SEARCH;
          good_d      = '0;
          frame_bad_d = 1'b0;
        end else if (v_as) begin
          frame_bad_d = 1'b0;
          if (frame_bad_q || mis_any) begin
            good_d = '0;
          end else if (good_q + 8'd1 >= 8'(LOCK_FRAMES)) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end else if (mis_any) begin
          good_d      = '0;
          frame_bad_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (mis_any || timeout) begin
          state_d = ST_SEARCH;
          err_set = 1'b1;
        end else if (v_as) begin
          frame_inc = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // FSM state and lock bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      good_q      <= '0;
      frame_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  // Verified-frame counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_inc) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  // Sticky error: keeps the first cause; a new error beats a same-clock clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else if (err_set) begin
      err_sticky_q <= 1'b1;
      if (err_code_q == ERR_NONE || bus.err_clr) begin
        err_code_q <= err_cause;
      end
    end else if (bus.err_clr) begin
      err_sticky_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end
  end

  // Last measured line period, captured at every hsync assert edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_period_q <= '0;
    end else if (h_as) begin
      h_period_q <= h_per;
    end
  end

  assign bus.locked        = (state_q == ST_LOCKED);
  assign bus.err_sticky    = err_sticky_q;
  assign bus.err_code      = err_code_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.line_cnt      = v_cnt;
  assign bus.h_period_meas = h_period_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a shrunken 24/4/10/2 timing so
// whole frames fit in a short run; pix_en pulses every 4th clock.
module tb_vga_sync_monitor;
  import vga_sync_monitor_pkg::*;

  localparam int HT = 24;
  localparam int HS = 4;
  localparam int VT = 10;
  localparam int VS = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_monitor_if bus();

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Driver tasks: one pixel tick = 4 clocks, inputs change on negedges.
  task automatic tick(input logic hs, input logic vs, input logic clr);
    @(negedge clk);
    bus.hsync   = hs;
    bus.vsync   = vs;
    bus.err_clr = clr;
    bus.pix_en  = 1'b1;
    @(negedge clk);
    bus.pix_en  = 1'b0;
    bus.err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Active-low sync: hsync low for 'width' ticks, vsync low for the whole line.
  task automatic send_line(input int period, input int width, input logic vs_act,
                           input logic clr_first);
    for (int i = 0; i < period; i++)
      tick((i < width) ? 1'b0 : 1'b1, vs_act ? 1'b0 : 1'b1, (i == 0) ? clr_first : 1'b0);
  endtask

  task automatic send_frame(input int first, input int last, input int vs_lines,
                            input int bad_line, input int bad_period, input int bad_width);
    for (int l = first; l <= last; l++)
      send_line((l == bad_line) ? bad_period : HT, (l == bad_line) ? bad_width : HS,
                l < vs_lines, 1'b0);
  endtask

  task automatic good_frames(input int n);
    repeat (n) send_frame(0, VT - 1, VS, -1, 0, 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0b want 0", bus.locked); end
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_sticky: got %0b want 0", bus.err_sticky); end
    n_cmp++; if (bus.err_code !== 3'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", bus.err_code); end
    n_cmp++; if (bus.frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt); end
    n_cmp++; if (bus.line_cnt !== 10'd0) begin n_bad++; $display("FAIL reset_line_cnt: got %0d want 0", bus.line_cnt); end
    n_cmp++; if (bus.h_period_meas !== 10'd0) begin n_bad++; $display("FAIL reset_h_period: got %0d want 0", bus.h_period_meas); end
    n_cmp++; if (bus.dbg_state !== ST_SEARCH) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
  endtask

  // Frames 1..5: edge 1 -> MEASURE, edge 2 -> one good frame, edge 3 -> LOCKED.
  task automatic test_lock();
    good_frames(2);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %0b want 0", bus.locked); end
    n_cmp++; if (bus.dbg_state !== ST_MEASURE) begin n_bad++; $display("FAIL lock_state_measure: got %0d want 1", bus.dbg_state); end
    n_cmp++; if (bus.line_cnt !== 10'd9) begin n_bad++; $display("FAIL lock_line_cnt: got %0d want 9", bus.line_cnt); end
    n_cmp++; if (bus.h_period_meas !== 10'd24) begin n_bad++; $display("FAIL lock_h_period: got %0d want 24", bus.h_period_meas); end
    good_frames(1);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL lock_third_edge: got %0b want 1", bus.locked); end
    n_cmp++; if (bus.frame_cnt !== 8'd0) begin n_bad++; $display("FAIL lock_frame_cnt0: got %0d want 0", bus.frame_cnt); end
    good_frames(2);
    n_cmp++; if (bus.frame_cnt !== 8'd2) begin n_bad++; $display("FAIL lock_frame_cnt2: got %0d want 2", bus.frame_cnt); end
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL lock_sticky: got %0b want 0", bus.err_sticky); end
  endtask

  // Frame 6 has a 23-tick line 3; relock over frames 7..9.
  task automatic test_h_period();
    send_frame(0, VT - 1, VS, 3, HT - 1, HS);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL hper_locked: got %0b want 0", bus.locked); end
    n_cmp++; if (bus.err_sticky !== 1'b1) begin n_bad++; $display("FAIL hper_sticky: got %0b want 1", bus.err_sticky); end
    n_cmp++; if (bus.err_code !== 3'd1) begin n_bad++; $display("FAIL hper_code: got %0d want 1", bus.err_code); end
    n_cmp++; if (bus.frame_cnt !== 8'd3) begin n_bad++; $display("FAIL hper_frame_cnt: got %0d want 3", bus.frame_cnt); end
    good_frames(2);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL hper_relock_early: got %0b want 0", bus.locked); end
    good_frames(1);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL hper_relock: got %0b want 1", bus.locked); end
    n_cmp++; if (bus.err_code !== 3'd1) begin n_bad++; $display("FAIL hper_code_held: got %0d want 1", bus.err_code); end
  endtask

  // Frame 10 has a 3-tick hsync on line 2; then clear and relock (11..13).
  task automatic test_h_width();
    pulse_clr();
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL hwid_clr1_sticky: got %0b want 0", bus.err_sticky); end
    n_cmp++; if (bus.err_code !== 3'd0) begin n_bad++; $display("FAIL hwid_clr1_code: got %0d want 0", bus.err_code); end
    send_frame(0, VT - 1, VS, 2, HT, HS - 1);
    n_cmp++; if (bus.err_code !== 3'd2) begin n_bad++; $display("FAIL hwid_code: got %0d want 2", bus.err_code); end
    n_cmp++; if (bus.frame_cnt !== 8'd4) begin n_bad++; $display("FAIL hwid_frame_cnt: got %0d want 4", bus.frame_cnt); end
    pulse_clr();
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL hwid_clr2_sticky: got %0b want 0", bus.err_sticky); end
    n_cmp++; if (bus.err_code !== 3'd0) begin n_bad++; $display("FAIL hwid_clr2_code: got %0d want 0", bus.err_code); end
    good_frames(3);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL hwid_relock: got %0b want 1", bus.locked); end
  endtask

  // Frame 14 has 9 lines (caught at frame 15's edge); relock 16..18;
  // frame 19 has a 3-line vsync which must not replace the first cause.
  task automatic test_v_lines();
    send_frame(0, VT - 2, VS, -1, 0, 0);
    good_frames(1);
    n_cmp++; if (bus.err_code !== 3'd3) begin n_bad++; $display("FAIL vlin_code: got %0d want 3", bus.err_code); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL vlin_locked: got %0b want 0", bus.locked); end
    n_cmp++; if (bus.frame_cnt !== 8'd5) begin n_bad++; $display("FAIL vlin_frame_cnt: got %0d want 5", bus.frame_cnt); end
    good_frames(3);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL vlin_relock: got %0b want 1", bus.locked); end
    send_frame(0, VT - 1, VS + 1, -1, 0, 0);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL vwid_locked: got %0b want 0", bus.locked); end
    n_cmp++; if (bus.err_sticky !== 1'b1) begin n_bad++; $display("FAIL vwid_sticky: got %0b want 1", bus.err_sticky); end
    n_cmp++; if (bus.err_code !== 3'd3) begin n_bad++; $display("FAIL vwid_code_kept: got %0d want 3", bus.err_code); end
    n_cmp++; if (bus.frame_cnt !== 8'd6) begin n_bad++; $display("FAIL vwid_frame_cnt: got %0d want 6", bus.frame_cnt); end
  endtask

  // Relock (20..22), then hsync held inactive: timeout on tick 1023 after the edge.
  task automatic test_timeout_locked();
    pulse_clr();
    good_frames(3);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL to_relock: got %0b want 1", bus.locked); end
    for (int i = 0; i < 1023; i++) tick((i < HS) ? 1'b0 : 1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL to_before_sticky: got %0b want 0", bus.err_sticky); end
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL to_before_locked: got %0b want 1", bus.locked); end
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.err_code !== 3'd5) begin n_bad++; $display("FAIL to_code: got %0d want 5", bus.err_code); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL to_locked: got %0b want 0", bus.locked); end
    for (int i = 1024; i < 1100; i++) tick(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.err_code !== 3'd5) begin n_bad++; $display("FAIL to_code_held: got %0d want 5", bus.err_code); end
  endtask

  // Relock (23..25); in frame 26 the line-3 edge errors on the same clock as err_clr.
  task automatic test_clr_collision();
    good_frames(3);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL coll_relock: got %0b want 1", bus.locked); end
    send_frame(0, 2, VS, 2, HT - 1, HS);
    send_line(HT, HS, 1'b0, 1'b1);
    n_cmp++; if (bus.err_sticky !== 1'b1) begin n_bad++; $display("FAIL coll_sticky: got %0b want 1", bus.err_sticky); end
    n_cmp++; if (bus.err_code !== 3'd1) begin n_bad++; $display("FAIL coll_code: got %0d want 1", bus.err_code); end
    n_cmp++; if (bus.h_period_meas !== 10'd23) begin n_bad++; $display("FAIL coll_h_period: got %0d want 23", bus.h_period_meas); end
    n_cmp++; if (bus.frame_cnt !== 8'd7) begin n_bad++; $display("FAIL coll_frame_cnt: got %0d want 7", bus.frame_cnt); end
    send_frame(4, VT - 1, VS, -1, 0, 0);
  endtask

  // A timeout while searching must leave the error flags alone.
  task automatic test_timeout_search();
    pulse_clr();
    send_line(1100, HS, 1'b0, 1'b0);
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL tos_sticky: got %0b want 0", bus.err_sticky); end
    n_cmp++; if (bus.err_code !== 3'd0) begin n_bad++; $display("FAIL tos_code: got %0d want 0", bus.err_code); end
    n_cmp++; if (bus.dbg_state !== ST_SEARCH) begin n_bad++; $display("FAIL tos_state: got %0d want 0", bus.dbg_state); end
  endtask

  // Lock (27..29), frame 30 counted, reset in the middle of frame 31.
  task automatic test_reset_mid();
    good_frames(4);
    send_frame(0, 4, VS, -1, 0, 0);
    n_cmp++; if (bus.frame_cnt !== 8'd9) begin n_bad++; $display("FAIL rmid_pre_frame_cnt: got %0d want 9", bus.frame_cnt); end
    n_cmp++; if (bus.line_cnt !== 10'd4) begin n_bad++; $display("FAIL rmid_pre_line_cnt: got %0d want 4", bus.line_cnt); end
    #2 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rmid_locked: got %0b want 0", bus.locked); end
    n_cmp++; if (bus.frame_cnt !== 8'd0) begin n_bad++; $display("FAIL rmid_frame_cnt: got %0d want 0", bus.frame_cnt); end
    n_cmp++; if (bus.line_cnt !== 10'd0) begin n_bad++; $display("FAIL rmid_line_cnt: got %0d want 0", bus.line_cnt); end
    n_cmp++; if (bus.h_period_meas !== 10'd0) begin n_bad++; $display("FAIL rmid_h_period: got %0d want 0", bus.h_period_meas); end
    @(negedge clk);
    rst = 1'b0;
    send_frame(5, VT - 1, VS, -1, 0, 0);
    good_frames(2);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rmid_lock_early: got %0b want 0", bus.locked); end
    good_frames(1);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL rmid_relock: got %0b want 1", bus.locked); end
    n_cmp++; if (bus.frame_cnt !== 8'd0) begin n_bad++; $display("FAIL rmid_frame_cnt_lock: got %0d want 0", bus.frame_cnt); end
    good_frames(1);
    n_cmp++; if (bus.frame_cnt !== 8'd1) begin n_bad++; $display("FAIL rmid_frame_cnt_next: got %0d want 1", bus.frame_cnt); end
  endtask

  initial begin
    bus.pix_en  = 1'b0;
    bus.hsync   = 1'b1;
    bus.vsync   = 1'b1;
    bus.err_clr = 1'b0;
    test_reset();
    test_lock();
    test_h_period();
    test_h_width();
    test_v_lines();
    test_timeout_locked();
    test_clr_collision();
    test_timeout_search();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Run-time bound.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached after %0d compares", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
